flash_prog_seq: RTL and testbench

- Flash programming/erase sequencer, downstream of the CPU register decode and upstream of the flash pins.
- Turns CPU register writes into JEDEC (AMD-style, word-mode) unlock/command bus cycles with timed WE_n pulses.
- Waits on FLASH_BUSY_n with a timeout and reports status.
- While active, the board pin mux routes FLASH address, data, WE_n and OE_n from this block instead of the read/maprom path.

---
 rtl/flash_prog_seq.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_flash_prog_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prog_seq.sv
// flash_prog_seq: turns CPU register writes into JEDEC (AMD-style, word-mode) unlock/command
// bus cycles with timed WE_n pulses, then polls FLASH_BUSY_n with a timeout.
// Optional feature macro: FLASH_SEQ_IRQ_EN adds the INT_n completion interrupt output.
module flash_prog_seq #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned PULSE_CYC    = 4,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned BUSY_DLY_CYC = 8,
    parameter logic [23:0] TIMEOUT_CYC  = 24'd12000000
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        REG_WR,
    input  logic        REG_RD,
    input  logic [2:0]  REG_ADDR,
    input  logic [15:0] REG_WDATA,
    output logic [15:0] REG_RDATA,
    output logic        SEQ_ACTIVE,
    output logic [18:0] FLASH_A,
    output logic [15:0] FLASH_DOUT,
    output logic        FLASH_WE_n,
    output logic        FLASH_OE_n,
`ifdef FLASH_SEQ_IRQ_EN
    output logic        INT_n,
`endif
    input  logic        FLASH_BUSY_n
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StWlow, StWhigh, StBdly, StPoll, StDone, StErr
    } state_e;

    localparam logic [1:0]  OpProg = 2'd1;
    localparam logic [1:0]  OpSect = 2'd3;

    localparam logic [3:0]  SetupLast   = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  PulseLast   = 4'(PULSE_CYC - 1);
    localparam logic [3:0]  HoldLast    = 4'(HOLD_CYC - 1);
    localparam logic [7:0]  DlyLast     = 8'(BUSY_DLY_CYC - 1);
    localparam logic [23:0] TimeoutLast = TIMEOUT_CYC - 24'd1;

    localparam logic [18:0] A555 = 19'h00555;
    localparam logic [18:0] A2AA = 19'h002AA;

    state_e      state_q, state_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  dly_q, dly_d;
    logic [23:0] tmo_q, tmo_d;

    logic [2:0]  addr_hi_q;
    logic [15:0] addr_lo_q;
    logic [15:0] data_q;
    logic        reject_q, reject_d;
    logic [15:0] rdata_q;
    logic        active_q, active_d;
    logic        we_n_q, we_n_d;
    logic [18:0] a_q, a_d;
    logic [15:0] dout_q, dout_d;

    logic        busy;
    logic        cmd_wr;
    logic        cmd_valid;
    logic        start;
    logic        reject_set;
    logic        load;
    logic [1:0]  load_op;
    logic [2:0]  load_idx;
    logic [2:0]  last_idx;
    logic [34:0] cyc_word;
    logic        irq_pend;
    logic [15:0] status;
    logic [15:0] rdata_mux;

    // Address/data of one command-table bus cycle, packed as {addr, data}.
    function automatic logic [34:0] cmd_cycle(input logic [1:0]  op,
                                              input logic [2:0]  idx,
                                              input logic [18:0] ta,
                                              input logic [15:0] wd);
        logic [34:0] r;
        case (idx)
            3'd0:    r = {A555, 16'h00AA};
            3'd1:    r = {A2AA, 16'h0055};
            3'd2:    r = {A555, (op == OpProg) ? 16'h00A0 : 16'h0080};
            3'd3:    r = (op == OpProg) ? {ta, wd} : {A555, 16'h00AA};
            3'd4:    r = {A2AA, 16'h0055};
            default: r = (op == OpSect) ? {ta, 16'h0030} : {A555, 16'h0010};
        endcase
        return r;
    endfunction

    assign busy      = !(state_q inside {StIdle, StDone, StErr});
    assign cmd_wr    = REG_WR && (REG_ADDR == 3'd3);
    assign cmd_valid = (REG_WDATA == 16'd1) || (REG_WDATA == 16'd2) || (REG_WDATA == 16'd3);
    assign start     = cmd_wr && cmd_valid && !busy;
    // Any write to ADDR_HI/ADDR_LO/DATA/CMD while a sequence runs is dropped and flagged.
    assign reject_set = REG_WR && busy && (REG_ADDR <= 3'd3);
    assign last_idx  = (opcode_q == OpProg) ? 3'd3 : 3'd5;

    // Next-state logic for the bus-cycle sequencer, BDLY wait and busy poll.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        dly_d    = dly_q;
        tmo_d    = tmo_q;
        load     = 1'b0;
        load_op  = opcode_q;
        load_idx = idx_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StSetup;
                    opcode_d = REG_WDATA[1:0];
                    idx_d    = 3'd0;
                    phase_d  = 4'd0;
                    load     = 1'b1;
                    load_op  = REG_WDATA[1:0];
                    load_idx = 3'd0;
                end
            end
            StSetup: begin
                if (phase_q == SetupLast) begin
                    state_d = StWlow;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StWlow: begin
                if (phase_q == PulseLast) begin
                    state_d = StWhigh;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StWhigh: begin
                if (phase_q != HoldLast) begin
                    phase_d = phase_q + 4'd1;
                end else if (idx_q == last_idx) begin
                    state_d = StBdly;
                    dly_d   = 8'd0;
                end else begin
                    state_d  = StSetup;
                    phase_d  = 4'd0;
                    idx_d    = idx_q + 3'd1;
                    load     = 1'b1;
                    load_idx = idx_q + 3'd1;
                end
            end
            StBdly: begin
                if (dly_q == DlyLast) begin
                    state_d = StPoll;
                    tmo_d   = 24'd0;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            StPoll: begin
                if (FLASH_BUSY_n) begin
                    state_d = StDone;
                end else if (tmo_q == TimeoutLast) begin
                    state_d = StErr;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered pin-side outputs; A/D only change on SETUP entry so they are stable per cycle.
    always_comb begin
        cyc_word = cmd_cycle(load_op, load_idx, {addr_hi_q, addr_lo_q}, data_q);
        a_d      = load ? cyc_word[34:16] : a_q;
        dout_d   = load ? cyc_word[15:0] : dout_q;
        we_n_d   = (state_d != StWlow);
        active_d = !(state_d inside {StIdle, StDone, StErr});
        reject_d = reject_q;
        if (start) begin
            reject_d = 1'b0;
        end else if (reject_set) begin
            reject_d = 1'b1;
        end
    end

    // Status word and read mux, built from pre-edge state.
    always_comb begin
        status = {11'd0, irq_pend, reject_q, state_q == StErr, state_q == StDone, busy};
        case (REG_ADDR)
            3'd0:    rdata_mux = {13'd0, addr_hi_q};
            3'd1:    rdata_mux = addr_lo_q;
            3'd2:    rdata_mux = data_q;
            3'd4:    rdata_mux = status;
            default: rdata_mux = 16'd0;
        endcase
    end

    // Sequencer state and pin-side output registers.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q  <= StIdle;
            opcode_q <= 2'd0;
            idx_q    <= 3'd0;
            phase_q  <= 4'd0;
            dly_q    <= 8'd0;
            tmo_q    <= 24'd0;
            reject_q <= 1'b0;
            active_q <= 1'b0;
            we_n_q   <= 1'b1;
            a_q      <= 19'd0;
            dout_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            dly_q    <= dly_d;
            tmo_q    <= tmo_d;
            reject_q <= reject_d;
            active_q <= active_d;
            we_n_q   <= we_n_d;
            a_q      <= a_d;
            dout_q   <= dout_d;
        end
    end

    // CPU-visible target address / data registers; frozen while a sequence runs.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            addr_hi_q <= 3'd0;
            addr_lo_q <= 16'd0;
            data_q    <= 16'd0;
        end else if (REG_WR && !busy) begin
            case (REG_ADDR)
                3'd0:    addr_hi_q <= REG_WDATA[2:0];
                3'd1:    addr_lo_q <= REG_WDATA;
                3'd2:    data_q    <= REG_WDATA;
                default: ;
            endcase
        end
    end

    // Read data register: captured on REG_RD, held otherwise.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            rdata_q <= 16'd0;
        end else if (REG_RD) begin
            rdata_q <= rdata_mux;
        end
    end

`ifdef FLASH_SEQ_IRQ_EN
    logic int_n_q, int_n_d;
    logic enter_fin;

    assign enter_fin = (state_q == StPoll) && (state_d inside {StDone, StErr});

    // Completion interrupt: asserted on DONE/ERR entry, cleared by a STATUS read or new start.
    always_comb begin
        int_n_d = int_n_q;
        if (enter_fin) begin
            int_n_d = 1'b0;
        end else if (start || (REG_RD && (REG_ADDR == 3'd4))) begin
            int_n_d = 1'b1;
        end
    end

    // Interrupt register.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= int_n_d;
        end
    end

    assign irq_pend = ~int_n_q;
    assign INT_n    = int_n_q;
`else
    assign irq_pend = 1'b0;
`endif

    assign REG_RDATA  = rdata_q;
    assign SEQ_ACTIVE = active_q;
    assign FLASH_A    = a_q;
    assign FLASH_DOUT = dout_q;
    assign FLASH_WE_n = we_n_q;
    // Reads never happen while this block owns the pins.
    assign FLASH_OE_n = 1'b1;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Testbench for flash_prog_seq: register vectors table plus directed multi-cycle sequences.
module tb_flash_prog_seq;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic        REG_WR;
    logic        REG_RD;
    logic [2:0]  REG_ADDR;
    logic [15:0] REG_WDATA;
    logic [15:0] REG_RDATA;
    logic        SEQ_ACTIVE;
    logic [18:0] FLASH_A;
    logic [15:0] FLASH_DOUT;
    logic        FLASH_WE_n;
    logic        FLASH_OE_n;
    logic        FLASH_BUSY_n;
`ifdef FLASH_SEQ_IRQ_EN
    logic        INT_n;
    localparam logic [15:0] IRQ_BIT = 16'h0010;
`else
    localparam logic [15:0] IRQ_BIT = 16'h0000;
`endif

    always #5 CLKCPU = ~CLKCPU;

    flash_prog_seq #(
        .TIMEOUT_CYC(24'd100)
    ) dut (
        .CLKCPU      (CLKCPU),
        .RESET       (RESET),
        .REG_WR      (REG_WR),
        .REG_RD      (REG_RD),
        .REG_ADDR    (REG_ADDR),
        .REG_WDATA   (REG_WDATA),
        .REG_RDATA   (REG_RDATA),
        .SEQ_ACTIVE  (SEQ_ACTIVE),
        .FLASH_A     (FLASH_A),
        .FLASH_DOUT  (FLASH_DOUT),
        .FLASH_WE_n  (FLASH_WE_n),
        .FLASH_OE_n  (FLASH_OE_n),
`ifdef FLASH_SEQ_IRQ_EN
        .INT_n       (INT_n),
`endif
        .FLASH_BUSY_n(FLASH_BUSY_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLKCPU) cyc <= cyc + 1;

    // WE_n pulse recorder (sampled on the falling clock edge).
    logic [18:0] p_a[$];
    logic [15:0] p_d[$];
    int          p_len[$];
    int          p_fall[$];
    int          p_rise[$];
    logic        we_prev = 1'b1;
    int          cur_len = 0;
    int          cur_fall = 0;
    logic [18:0] cur_a;
    logic [15:0] cur_d;
    int          unstable = 0;

    always @(negedge CLKCPU) begin
        if (FLASH_WE_n === 1'b0) begin
            if (we_prev) begin
                cur_len  = 1;
                cur_a    = FLASH_A;
                cur_d    = FLASH_DOUT;
                cur_fall = cyc;
            end else begin
                cur_len++;
                if (FLASH_A !== cur_a || FLASH_DOUT !== cur_d) unstable++;
            end
        end else if (!we_prev) begin
            p_a.push_back(cur_a);
            p_d.push_back(cur_d);
            p_len.push_back(cur_len);
            p_fall.push_back(cur_fall);
            p_rise.push_back(cyc);
        end
        we_prev = FLASH_WE_n;
    end

    logic [18:0] exp_a[6];
    logic [15:0] exp_d[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        REG_WR    = 1'b1;
        REG_ADDR  = a;
        REG_WDATA = d;
        @(posedge CLKCPU);
        #1;
        REG_WR = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        REG_RD   = 1'b1;
        REG_ADDR = a;
        @(posedge CLKCPU);
        #1;
        REG_RD = 1'b0;
        d      = REG_RDATA;
    endtask

    task automatic clear_pulses();
        p_a.delete();
        p_d.delete();
        p_len.delete();
        p_fall.delete();
        p_rise.delete();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (SEQ_ACTIVE === 1'b1 && n < 2000) begin
            @(posedge CLKCPU);
            #1;
            n++;
        end
    endtask

    task automatic set_prog(input logic [18:0] ta, input logic [15:0] d);
        exp_a[0] = 19'h00555; exp_d[0] = 16'h00AA;
        exp_a[1] = 19'h002AA; exp_d[1] = 16'h0055;
        exp_a[2] = 19'h00555; exp_d[2] = 16'h00A0;
        exp_a[3] = ta;        exp_d[3] = d;
    endtask

    task automatic set_erase(input logic sect, input logic [18:0] ta);
        exp_a[0] = 19'h00555; exp_d[0] = 16'h00AA;
        exp_a[1] = 19'h002AA; exp_d[1] = 16'h0055;
        exp_a[2] = 19'h00555; exp_d[2] = 16'h0080;
        exp_a[3] = 19'h00555; exp_d[3] = 16'h00AA;
        exp_a[4] = 19'h002AA; exp_d[4] = 16'h0055;
        exp_a[5] = sect ? ta : 19'h00555;
        exp_d[5] = sect ? 16'h0030 : 16'h0010;
    endtask

    task automatic check_pulses(input string tag, input int n);
        chk($sformatf("%s_npulses", tag), p_a.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < p_a.size()) begin
                chk($sformatf("%s_p%0d_addr", tag, i), p_a[i], exp_a[i]);
                chk($sformatf("%s_p%0d_data", tag, i), p_d[i], exp_d[i]);
                chk($sformatf("%s_p%0d_len", tag, i), p_len[i], 4);
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int          n;
        int          cmd_cyc;
        logic [18:0] ta;

        ta = {3'd1, 16'h2345};

        vecs[0]  = '{1'b0, 3'd4, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 3'd0, 16'hFFFF, 16'h0000};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 16'h0007};
        vecs[4]  = '{1'b1, 3'd1, 16'h2345, 16'h0000};
        vecs[5]  = '{1'b0, 3'd1, 16'h0000, 16'h2345};
        vecs[6]  = '{1'b1, 3'd2, 16'hBEEF, 16'h0000};
        vecs[7]  = '{1'b0, 3'd2, 16'h0000, 16'hBEEF};
        vecs[8]  = '{1'b1, 3'd3, 16'h0007, 16'h0000};
        vecs[9]  = '{1'b0, 3'd4, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 3'd3, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 3'd5, 16'h1234, 16'h0000};
        vecs[12] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        vecs[13] = '{1'b0, 3'd7, 16'h0000, 16'h0000};
        vecs[14] = '{1'b1, 3'd0, 16'h0001, 16'h0000};
        vecs[15] = '{1'b0, 3'd0, 16'h0000, 16'h0001};

        RESET        = 1'b1;
        REG_WR       = 1'b0;
        REG_RD       = 1'b0;
        REG_ADDR     = 3'd0;
        REG_WDATA    = 16'd0;
        FLASH_BUSY_n = 1'b1;
        repeat (3) @(posedge CLKCPU);
        #1;
        RESET = 1'b0;

        chk("rst_rdata", REG_RDATA, 16'h0);
        chk("rst_active", SEQ_ACTIVE, 1'b0);
        chk("rst_addr", FLASH_A, 19'h0);
        chk("rst_dout", FLASH_DOUT, 16'h0);
        chk("rst_we_n", FLASH_WE_n, 1'b1);
        chk("rst_oe_n", FLASH_OE_n, 1'b1);
`ifdef FLASH_SEQ_IRQ_EN
        chk("rst_int_n", INT_n, 1'b1);
`endif

        // Register access table.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, r);
                chk($sformatf("vec%0d_rd%0d", i, vecs[i].addr), r, vecs[i].exp);
            end
        end
        chk("invalid_cmd_active", SEQ_ACTIVE, 1'b0);
        @(posedge CLKCPU);
        #1;
        chk("rdata_hold", REG_RDATA, 16'h0001);

        // Program with busy held low ~20 poll clocks.
        wr(3'd1, 16'h2345);
        FLASH_BUSY_n = 1'b0;
        clear_pulses();
        wr(3'd3, 16'd1);
        cmd_cyc = cyc;
        chk("prog_active_start", SEQ_ACTIVE, 1'b1);
        rd(3'd4, r);
        chk("prog_status_busy", r, 16'h0001);
        while (cyc < cmd_cyc + 60) begin
            @(posedge CLKCPU);
            #1;
        end
        chk("prog_polling_active", SEQ_ACTIVE, 1'b1);
        FLASH_BUSY_n = 1'b1;
        @(posedge CLKCPU);
        #1;
        chk("prog_done_active", SEQ_ACTIVE, 1'b0);
`ifdef FLASH_SEQ_IRQ_EN
        chk("prog_int_n_low", INT_n, 1'b0);
`endif
        set_prog(ta, 16'hBEEF);
        check_pulses("prog", 4);
        if (p_fall.size() == 4) begin
            chk("prog_first_fall", p_fall[0] - cmd_cyc, 2);
            chk("prog_last_rise", p_rise[3] - cmd_cyc, 30);
        end
        rd(3'd4, r);
        chk("prog_status_done", r, 16'h0002 | IRQ_BIT);
`ifdef FLASH_SEQ_IRQ_EN
        chk("prog_int_n_clr", INT_n, 1'b1);
`endif
        rd(3'd4, r);
        chk("prog_status_sticky", r, 16'h0002);
        chk("prog_we_n_idle", FLASH_WE_n, 1'b1);

        // Chip erase: 6 cycles, last WE_n rise at +46, DONE edge at +48+8+1.
        clear_pulses();
        wr(3'd3, 16'd2);
        cmd_cyc = cyc;
        rd(3'd4, r);
        chk("chip_status_busy0", r, 16'h0001);
        while (cyc < cmd_cyc + 40) begin
            @(posedge CLKCPU);
            #1;
        end
        rd(3'd4, r);
        chk("chip_status_busy1", r, 16'h0001);
        wait_idle(n);
        chk("chip_done_cycle", cyc - cmd_cyc, 57);
        set_erase(1'b0, ta);
        check_pulses("chip", 6);
        if (p_rise.size() == 6) chk("chip_last_rise", p_rise[5] - cmd_cyc, 46);
        rd(3'd4, r);
        chk("chip_status_done", r, 16'h0002 | IRQ_BIT);

        // Sector erase.
        clear_pulses();
        wr(3'd3, 16'd3);
        wait_idle(n);
        set_erase(1'b1, ta);
        check_pulses("sect", 6);
        rd(3'd4, r);
        chk("sect_status_done", r, 16'h0002 | IRQ_BIT);

        // Timeout: POLL at +40, ERR 100 clocks later.
        FLASH_BUSY_n = 1'b0;
        wr(3'd3, 16'd1);
        cmd_cyc = cyc;
        wait_idle(n);
        chk("tmo_err_cycle", cyc - cmd_cyc, 140);
        rd(3'd4, r);
        chk("tmo_status", r, 16'h0004 | IRQ_BIT);
        chk("tmo_we_n", FLASH_WE_n, 1'b1);
        FLASH_BUSY_n = 1'b1;

        // Reject: CMD and DATA writes during SETUP leave the sequence unchanged.
        clear_pulses();
        wr(3'd3, 16'd1);
        cmd_cyc = cyc;
        wr(3'd3, 16'd3);
        wr(3'd2, 16'h1234);
        wait_idle(n);
        chk("rej_done_cycle", cyc - cmd_cyc, 41);
        set_prog(ta, 16'hBEEF);
        check_pulses("rej", 4);
        rd(3'd4, r);
        chk("rej_status", r, 16'h000A | IRQ_BIT);
        rd(3'd2, r);
        chk("rej_data_kept", r, 16'hBEEF);

        // Reset during WLOW.
        wr(3'd3, 16'd1);
        n = 0;
        while (FLASH_WE_n !== 1'b0 && n < 50) begin
            @(posedge CLKCPU);
            #1;
            n++;
        end
        chk("rstmid_in_wlow", FLASH_WE_n, 1'b0);
        RESET = 1'b1;
        @(posedge CLKCPU);
        #1;
        RESET = 1'b0;
        chk("rstmid_we_n", FLASH_WE_n, 1'b1);
        chk("rstmid_active", SEQ_ACTIVE, 1'b0);
        rd(3'd4, r);
        chk("rstmid_status", r, 16'h0000);
        rd(3'd2, r);
        chk("rstmid_data_clr", r, 16'h0000);
        wr(3'd0, 16'd1);
        wr(3'd1, 16'h2345);
        wr(3'd2, 16'hBEEF);
        clear_pulses();
        wr(3'd3, 16'd1);
        cmd_cyc = cyc;
        wait_idle(n);
        chk("rstmid_rerun_cycle", cyc - cmd_cyc, 41);
        check_pulses("rerun", 4);
        rd(3'd4, r);
        chk("rstmid_rerun_status", r, 16'h0002 | IRQ_BIT);

        chk("ad_stable_in_pulse", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
